bcd_time_counter: RTL and testbench

//  Parametrised BCD mm..m:ss time counter for the stopwatch/timer datapath.

---
 rtl/bcd_time_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 36 +++
 rtl/bcd_time_counter.sv | 81 ++++++++
 tb/tb_bcd_time_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// Shared constants and helpers for the BCD mm..m:ss time counter.
package bcd_time_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_MAX      = 4'd9;

    function automatic logic [DIGIT_W-1:0] bcd_clamp(
        input logic [DIGIT_W-1:0] val,
        input logic [DIGIT_W-1:0] max
    );
        return (val > max) ? max : val;
    endfunction

    // Digit 0 is seconds ones, digit 1 seconds tens, everything above is minutes.
    function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
        if (idx == 0)      return SEC_ONES_MAX;
        else if (idx == 1) return SEC_TENS_MAX;
        else               return MIN_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with load, increment and decrement; exposes wrap strobes for the ripple chain.
module bcd_digit
    import bcd_time_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_dec,
    input  logic               i_ld,
    input  logic [DIGIT_W-1:0] i_ld_val,
    output logic [DIGIT_W-1:0] o_q,
    output logic               o_cout,
    output logic               o_bout
);

    logic [DIGIT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_ld_val;
        end else if (i_inc) begin
            r_q <= (r_q == MAX) ? '0 : r_q + 4'd1;
        end else if (i_dec) begin
            r_q <= (r_q == '0) ? MAX : r_q - 4'd1;
        end
    end

    assign o_q    = r_q;
    assign o_cout = i_inc && (r_q == MAX);
    assign o_bout = i_dec && (r_q == '0);

endmodule

// File: rtl/bcd_time_counter.sv
// BCD mm..m:ss up/down time counter: load decode, terminal detect and term pulse around a digit chain.
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter bit WRAP       = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_tick,
    input  logic                                i_run,
    input  logic                                i_down,
    input  logic                                i_ld_en,
    input  logic [2:0]                          i_ld_sel,
    input  logic [DIGIT_W-1:0]                  i_ld_val,
    output logic [DIGIT_W*(MIN_DIGITS+2)-1:0]   o_digits,
    output logic                                o_at_zero,
    output logic                                o_term
);

    localparam int D = MIN_DIGITS + 2;

    logic [D:0]   w_inc_chain;
    logic [D:0]   w_dec_chain;
    logic [D-1:0] w_at_max;
    logic [D-1:0] w_at_min;
    logic         w_count;
    logic         w_term_now;
    logic         w_step;
    logic         w_term_next;
    logic         r_term;

    assign w_count    = i_tick && i_run && !i_ld_en;
    assign w_term_now = i_down ? (&w_at_min) : (&w_at_max);
    // Without wrap the chain is simply not stepped at terminal, so digits hold.
    assign w_step     = w_count && (WRAP || !w_term_now);

    assign w_inc_chain[0] = w_step && !i_down;
    assign w_dec_chain[0] = w_step && i_down;

    for (genvar g = 0; g < D; g++) begin : g_digit
        localparam logic [DIGIT_W-1:0] DMAX = digit_max(g);

        logic               w_ld;
        logic [DIGIT_W-1:0] w_ld_val;

        assign w_ld     = i_ld_en && (i_ld_sel == 3'(g));
        assign w_ld_val = bcd_clamp(i_ld_val, DMAX);

        bcd_digit #(.MAX(DMAX)) u_digit (
            .clk      (clk),
            .rst      (rst),
            .i_inc    (w_inc_chain[g]),
            .i_dec    (w_dec_chain[g]),
            .i_ld     (w_ld),
            .i_ld_val (w_ld_val),
            .o_q      (o_digits[DIGIT_W*g +: DIGIT_W]),
            .o_cout   (w_inc_chain[g+1]),
            .o_bout   (w_dec_chain[g+1])
        );

        assign w_at_max[g] = (o_digits[DIGIT_W*g +: DIGIT_W] == DMAX);
        assign w_at_min[g] = (o_digits[DIGIT_W*g +: DIGIT_W] == '0);
    end

    // With wrap, a carry/borrow leaving the top digit is exactly the terminal event.
    assign w_term_next = WRAP ? (w_inc_chain[D] || w_dec_chain[D])
                              : (w_count && w_term_now);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_term <= 1'b0;
        end else begin
            r_term <= w_term_next;
        end
    end

    assign o_term    = r_term;
    assign o_at_zero = &w_at_min;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: two counters (wrap / hold) against a seconds-based reference model.
module tb_bcd_time_counter;

    localparam int MD   = 2;
    localparam int D    = MD + 2;
    localparam int MAXT = 100 * 60 - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             run = 1'b0;
    logic             down = 1'b0;
    logic             ld_en = 1'b0;
    logic [2:0]       ld_sel = '0;
    logic [3:0]       ld_val = '0;
    logic [4*D-1:0]   digits_w, digits_h;
    logic             at_zero_w, at_zero_h;
    logic             term_w, term_h;

    bcd_time_counter #(.MIN_DIGITS(MD), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .i_tick(tick), .i_run(run), .i_down(down),
        .i_ld_en(ld_en), .i_ld_sel(ld_sel), .i_ld_val(ld_val),
        .o_digits(digits_w), .o_at_zero(at_zero_w), .o_term(term_w)
    );

    bcd_time_counter #(.MIN_DIGITS(MD), .WRAP(1'b0)) u_hold (
        .clk(clk), .rst(rst), .i_tick(tick), .i_run(run), .i_down(down),
        .i_ld_en(ld_en), .i_ld_sel(ld_sel), .i_ld_val(ld_val),
        .o_digits(digits_h), .o_at_zero(at_zero_h), .o_term(term_h)
    );

    typedef struct packed {
        logic [4*D-1:0] digits;
        logic           at_zero;
        logic           term;
    } exp_t;

    exp_t q_w[$];
    exp_t q_h[$];
    int   checks = 0;
    int   failures = 0;
    int   t_w = 0;
    int   t_h = 0;

    function automatic logic [4*D-1:0] to_bcd(input int t);
        logic [4*D-1:0] d;
        int m, s;
        s = t % 60;
        m = t / 60;
        d = '0;
        d[3:0] = 4'(s % 10);
        d[7:4] = 4'(s / 10);
        for (int k = 0; k < MD; k++) begin
            d[4*(k+2) +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return d;
    endfunction

    function automatic int from_bcd(input logic [4*D-1:0] d);
        int m, w;
        m = 0;
        w = 1;
        for (int k = 0; k < MD; k++) begin
            m = m + w * int'(d[4*(k+2) +: 4]);
            w = w * 10;
        end
        return m * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    // Next time value in seconds given the currently driven inputs.
    function automatic int next_t(input int t, input bit wrap, output bit term_o);
        logic [4*D-1:0] d;
        int mx, v;
        term_o = 1'b0;
        if (rst) return 0;
        if (ld_en) begin
            if (int'(ld_sel) < D) begin
                d  = to_bcd(t);
                mx = (ld_sel == 3'd1) ? 5 : 9;
                v  = (int'(ld_val) > mx) ? mx : int'(ld_val);
                d[4*ld_sel +: 4] = 4'(v);
                return from_bcd(d);
            end
            return t;
        end
        if (tick && run) begin
            if (!down) begin
                if (t == MAXT) begin
                    term_o = 1'b1;
                    return wrap ? 0 : t;
                end
                return t + 1;
            end else begin
                if (t == 0) begin
                    term_o = 1'b1;
                    return wrap ? MAXT : 0;
                end
                return t - 1;
            end
        end
        return t;
    endfunction

    task automatic step(input bit r, input bit l, input int sel, input int val,
                        input bit tk, input bit rn, input bit dn);
        bit tw, th;
        @(negedge clk);
        #1;
        rst = r; ld_en = l; ld_sel = 3'(sel); ld_val = 4'(val);
        tick = tk; run = rn; down = dn;
        t_w = next_t(t_w, 1'b1, tw);
        t_h = next_t(t_h, 1'b0, th);
        q_w.push_back('{digits: to_bcd(t_w), at_zero: (t_w == 0), term: tw});
        q_h.push_back('{digits: to_bcd(t_h), at_zero: (t_h == 0), term: th});
    endtask

    task automatic ticks(input int n, input bit dn);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 1, dn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, down);
    endtask

    task automatic load_time(input int m1, input int m0, input int s1, input int s0);
        step(0, 1, 3, m1, 0, 1, down);
        step(0, 1, 2, m0, 0, 1, down);
        step(0, 1, 1, s1, 0, 1, down);
        step(0, 1, 0, s0, 0, 1, down);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q_w.size() > 0) begin
            e = q_w.pop_front();
            chk("wrap_digits", 32'(digits_w), 32'(e.digits));
            chk("wrap_at_zero", 32'(at_zero_w), 32'(e.at_zero));
            chk("wrap_term", 32'(term_w), 32'(e.term));
        end
        if (q_h.size() > 0) begin
            e = q_h.pop_front();
            chk("hold_digits", 32'(digits_h), 32'(e.digits));
            chk("hold_at_zero", 32'(at_zero_h), 32'(e.at_zero));
            chk("hold_term", 32'(term_h), 32'(e.term));
        end
    end

    initial begin
        int n;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // count up from reset through a minute carry
        ticks(61, 0);
        idle(2);

        // terminal going up: wrap vs hold, then a second terminal tick on the hold copy
        load_time(9, 9, 5, 9);
        ticks(1, 0);
        idle(2);
        ticks(1, 0);
        idle(1);

        // countdown to zero and past it
        load_time(0, 1, 0, 0);
        ticks(1, 1);
        ticks(59, 1);
        idle(1);
        ticks(1, 1);
        idle(2);

        // pause and load/tick collision
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 3, 1, 1, 0);
        idle(1);

        // out-of-range loads
        step(0, 1, 1, 8, 0, 1, 0);
        step(0, 1, 0, 12, 0, 1, 0);
        step(0, 1, 7, 4, 0, 1, 0);
        step(0, 1, 5, 4, 0, 1, 0);
        idle(1);

        // reset coinciding with a terminal tick
        load_time(9, 9, 5, 9);
        step(1, 0, 0, 0, 1, 1, 0);
        idle(2);

        // randomized traffic with periodic jumps near the terminal counts
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                n = int'($urandom_range(0, 2));
                if (n == 0)      load_time(9, 9, 5, 9);
                else if (n == 1) load_time(0, 0, 0, 0);
                else load_time(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                               int'($urandom_range(0, 5)), int'($urandom_range(0, 9)));
            end
            step(($urandom % 80) == 0, ($urandom % 10) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 ($urandom % 3) != 0, ($urandom % 5) != 0, ($urandom % 2) == 1);
        end
        idle(1);

        n = 0;
        while ((q_w.size() > 0 || q_h.size() > 0) && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (q_w.size() > 0 || q_h.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending entries", q_w.size() + q_h.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
